// File: rtl/sipo_deser_pkg.sv
// Shared types and limits for the sipo_deser serial-to-parallel deserializer.
package sipo_deser_pkg;

  // Widest word the deserializer supports.
  localparam int unsigned MAX_WIDTH = 32;

  // S_PAR is reachable only when PARITY_CHECK_EN is defined.
  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_PAR
  } state_t;

endpackage

// File: rtl/sipo_deser_if.sv
// Serial input / parallel output bundle for sipo_deser.
// master drives the serial side and consumes words; slave is the deserializer.
interface sipo_deser_if #(
  parameter int unsigned WIDTH = 8
);
  logic             sdi;
  logic             sdi_vld;
  logic             clear;
  logic [WIDTH-1:0] pdo;
  logic             pdo_vld;
  logic             pdo_rdy;
  logic             ovr;
  logic             par_err;

  modport master (
    output sdi, sdi_vld, clear, pdo_rdy,
    input  pdo, pdo_vld, ovr, par_err
  );

  modport slave (
    input  sdi, sdi_vld, clear, pdo_rdy,
    output pdo, pdo_vld, ovr, par_err
  );
endinterface

// File: rtl/sipo_out_reg.sv
// One-entry valid/ready holding register for completed words.
// A load into an occupied, unconsumed slot is dropped and reported on drop.
module sipo_out_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             rdy,
  output logic [WIDTH-1:0] pdo,
  output logic             pdo_vld,
  output logic             drop
);
  logic [WIDTH-1:0] pdo_d, pdo_q;
  logic             vld_d, vld_q;
  logic             free;

  // Slot is free when empty or being drained this cycle.
  assign free = !vld_q || rdy;
  assign drop = load && !free;

  // Next-state: load replaces (even on a same-cycle consume), else a transfer empties the slot.
  always_comb begin
    pdo_d = pdo_q;
    vld_d = vld_q;
    if (load && free) begin
      pdo_d = word;
      vld_d = 1'b1;
    end else if (vld_q && rdy) begin
      vld_d = 1'b0;
    end
  end

  // Holding register state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pdo_q <= '0;
      vld_q <= 1'b0;
    end else begin
      pdo_q <= pdo_d;
      vld_q <= vld_d;
    end
  end

  assign pdo     = pdo_q;
  assign pdo_vld = vld_q;
endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: assembles WIDTH-bit words LSB first and hands
// them to a one-entry valid/ready output register, flagging overrun on a dropped word.
// Optional build macro PARITY_CHECK_EN: an even-parity bit follows each word.
module sipo_deser
  import sipo_deser_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  sipo_deser_if.slave bus
);
  localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : gen_width_err
    $error("sipo_deser: WIDTH out of range");
  end

  state_t           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [WIDTH-1:0] shreg_d, shreg_q;
  logic [WIDTH-1:0] load_word;
  logic             load;
  logic             drop;
  logic             ovr_d, ovr_q;
`ifdef PARITY_CHECK_EN
  logic             par_err_d, par_err_q;
`endif

  // FSM next-state, bit capture and word-complete decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    load      = 1'b0;
    load_word = shreg_q;
`ifdef PARITY_CHECK_EN
    par_err_d = 1'b0;
`endif
    if (bus.clear) begin
      // Abort wins over a coincident strobe; the output slot is left alone.
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (bus.sdi_vld) begin
      case (state_q)
        S_IDLE: begin
          shreg_d[0] = bus.sdi;
          cnt_d      = CNT_W'(1);
          state_d    = S_SHIFT;
        end
        S_SHIFT: begin
          for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q == CNT_W'(i)) shreg_d[i] = bus.sdi;
          end
          if (cnt_q == LAST_BIT) begin
            cnt_d = '0;
`ifdef PARITY_CHECK_EN
            state_d = S_PAR;
`else
            load      = 1'b1;
            load_word = shreg_d;
            state_d   = S_IDLE;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef PARITY_CHECK_EN
        S_PAR: begin
          // Even parity: word plus parity bit must XOR to zero.
          if (^{shreg_q, bus.sdi}) par_err_d = 1'b1;
          else                     load      = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
`endif
        default: begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Sticky overrun: set by a dropped word, cleared only by clear or reset.
  always_comb begin
    ovr_d = bus.clear ? 1'b0 : (ovr_q || drop);
  end

  // Deserializer state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef PARITY_CHECK_EN
  // One-cycle parity error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_err_q <= 1'b0;
    else      par_err_q <= par_err_d;
  end
  assign bus.par_err = par_err_q;
`else
  assign bus.par_err = 1'b0;
`endif

  assign bus.ovr = ovr_q;

  sipo_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .word    (load_word),
    .rdy     (bus.pdo_rdy),
    .pdo     (bus.pdo),
    .pdo_vld (bus.pdo_vld),
    .drop    (drop)
  );
endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser (WIDTH=8) with an expected-word scoreboard.
module tb_sipo_deser;
  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  logic [WIDTH-1:0] sb[$];

  sipo_deser_if #(.WIDTH(WIDTH)) bus ();

  sipo_deser #(
    .WIDTH (WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare the presented word against the scoreboard head and retire it.
  task automatic expect_word(input string tag);
    logic [WIDTH-1:0] exp;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      exp = sb.pop_front();
      check({tag, "_vld"}, 32'(bus.pdo_vld), 32'd1);
      check(tag, 32'(bus.pdo), 32'(exp));
    end
  endtask

  // Drive bits lo..hi of w (LSB first), gap idle cycles after each strobe; ends on a negedge.
  task automatic send_bits(input logic [31:0] w, input int lo, input int hi, input int gap);
    for (int i = lo; i <= hi; i++) begin
      bus.sdi     = w[i];
      bus.sdi_vld = 1'b1;
      @(negedge clk);
      bus.sdi_vld = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    rst         = 1'b0;
    bus.sdi     = 1'b0;
    bus.sdi_vld = 1'b0;
    bus.clear   = 1'b0;
    bus.pdo_rdy = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_pdo", 32'(bus.pdo), 32'h0);
    check("rst_vld", 32'(bus.pdo_vld), 32'd0);
    check("rst_ovr", 32'(bus.ovr), 32'd0);
    check("rst_par_err", 32'(bus.par_err), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 1: basic word, consumer ready
    bus.pdo_rdy = 1'b1;
    sb.push_back(8'hA5);
    send_bits(32'hA5, 0, 7, 0);
    expect_word("t1_pdo");
    @(negedge clk);
    check("t1_vld_drop", 32'(bus.pdo_vld), 32'd0);
    bus.pdo_rdy = 1'b0;

    // 2: overrun with consumer stalled, then clear
    sb.push_back(8'h3C);
    send_bits(32'h3C, 0, 7, 0);
    check("t2_first", 32'(bus.pdo), 32'(sb[0]));
    check("t2_no_ovr", 32'(bus.ovr), 32'd0);
    send_bits(32'hC3, 0, 7, 0);
    check("t2_ovr", 32'(bus.ovr), 32'd1);
    check("t2_hold", 32'(bus.pdo), 32'(sb[0]));
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    check("t2_ovr_clr", 32'(bus.ovr), 32'd0);
    check("t2_keep_vld", 32'(bus.pdo_vld), 32'd1);
    bus.pdo_rdy = 1'b1;
    expect_word("t2_pdo");
    @(negedge clk);
    bus.pdo_rdy = 1'b0;
    check("t2_vld_drop", 32'(bus.pdo_vld), 32'd0);

    // 3: consume old word in the same cycle the new one loads
    sb.push_back(8'h11);
    send_bits(32'h11, 0, 7, 0);
    sb.push_back(8'h22);
    send_bits(32'h22, 0, 6, 0);
    check("t3_held", 32'(bus.pdo), 32'h11);
    bus.sdi     = 1'b0;
    bus.sdi_vld = 1'b1;
    bus.pdo_rdy = 1'b1;
    expect_word("t3_old");
    @(negedge clk);
    bus.sdi_vld = 1'b0;
    bus.pdo_rdy = 1'b0;
    check("t3_new", 32'(bus.pdo), 32'(sb[0]));
    check("t3_vld", 32'(bus.pdo_vld), 32'd1);
    check("t3_ovr", 32'(bus.ovr), 32'd0);
    bus.pdo_rdy = 1'b1;
    expect_word("t3_pdo");
    @(negedge clk);
    bus.pdo_rdy = 1'b0;

    // 4: reset mid-word, then a full word
    send_bits(32'h0A, 0, 3, 0);
    rst = 1'b0;
    @(negedge clk);
    check("t4_rst_vld", 32'(bus.pdo_vld), 32'd0);
    check("t4_rst_pdo", 32'(bus.pdo), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    bus.pdo_rdy = 1'b1;
    sb.push_back(8'hFF);
    send_bits(32'hFF, 0, 7, 0);
    expect_word("t4_pdo");
    @(negedge clk);

    // clear beats a coincident strobe
    bus.clear   = 1'b1;
    bus.sdi     = 1'b1;
    bus.sdi_vld = 1'b1;
    @(negedge clk);
    bus.clear   = 1'b0;
    bus.sdi_vld = 1'b0;
    sb.push_back(8'h00);
    send_bits(32'h00, 0, 7, 0);
    expect_word("clr_pdo");
    @(negedge clk);

    // 5: gapped strobes, counter holds across idle cycles
    sb.push_back(8'h81);
    send_bits(32'h81, 0, 6, 2);
    repeat (4) @(negedge clk);
    check("t5_partial_vld", 32'(bus.pdo_vld), 32'd0);
    send_bits(32'h81, 7, 7, 0);
    expect_word("t5_pdo");
    check("t5_par_err", 32'(bus.par_err), 32'd0);
    @(negedge clk);
    bus.pdo_rdy = 1'b0;

`ifdef PARITY_CHECK_EN
    // 6: parity good then bad
    sb.push_back(8'h07);
    send_bits(32'h107, 0, 8, 0);
    check("t6_good_err", 32'(bus.par_err), 32'd0);
    check("t6_good_pdo", 32'(bus.pdo), 32'(sb[0]));
    check("t6_good_vld", 32'(bus.pdo_vld), 32'd1);
    send_bits(32'h007, 0, 8, 0);
    check("t6_bad_err", 32'(bus.par_err), 32'd1);
    check("t6_bad_vld", 32'(bus.pdo_vld), 32'd1);
    check("t6_bad_ovr", 32'(bus.ovr), 32'd0);
    @(negedge clk);
    check("t6_err_pulse", 32'(bus.par_err), 32'd0);
    bus.pdo_rdy = 1'b1;
    expect_word("t6_pdo");
    @(negedge clk);
    bus.pdo_rdy = 1'b0;
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
